wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline write-back stage and a long-latency unit (mul/div) result stream.
- The pipeline write-back always has priority and is never stalled by this block.
- Long-latency results are held in a small FIFO and drained into free write-back slots.
- A starvation timer raises a stall request so that the FIFO is guaranteed to drain.
- A pending-rd query lets the hazard unit block RAW/WAW on results still held in the FIFO.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before stall_req asserts; at least 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- pipe_rd_en  in  1  write-back stage wants to write
- pipe_rd  in  5  write-back destination register
- pipe_result  in  64  write-back data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result
- lu_rd  in  5  long-latency destination register
- lu_result  in  64  long-latency data
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  64  register-file write data
- stall_req  out  1  request a pipeline bubble so the FIFO can drain
- query_rd  in  5  register index from the hazard unit
- query_hit  out  1  query_rd is pending in the FIFO
- fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers 0, wait counter 0, state IDLE. Outputs: lu_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, query_hit=0, fifo_count=0. A reset mid-operation discards pending entries.
- Pipe slot "busy" = pipe_rd_en && pipe_rd!=0. A write with pipe_rd=0 is treated as no write.
- Write port is combinational, same cycle:
  - If busy: rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_result.
  - Else if FIFO non-empty: write the head and pop it at the clock edge.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- FIFO push: lu_ready = (count != DEPTH), derived from registered count only.
  - A push occurs when lu_valid && lu_ready.
  - Full plus a same-cycle pop does NOT allow a push.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - An lu_rd=0 result is accepted and then dropped: it is popped without rf_we.
- Minimum latency from lu push to rf write is 1 cycle. There is no bypass.
- State machine:
  - IDLE: FIFO empty, counter 0.
    - Push -> WAIT.
  - WAIT: head valid.
    - Each cycle the head is not popped, counter increments (saturates at STARVE_LIMIT).
    - Pop leaving the FIFO non-empty: counter -> 0, stay WAIT.
    - Pop leaving the FIFO empty: -> IDLE.
    - Counter reaches STARVE_LIMIT -> FORCE.
  - FORCE: stall_req=1, registered.
    - Held until the head pops; then counter -> 0 and go to WAIT or IDLE per occupancy.
    - If pipe slot stays busy in FORCE (stall takes effect late), the pipe still wins.
- query_hit = OR over valid entries of (entry.rd == query_rd && query_rd != 0). Computed combinationally from registered state.
- Ordering contract: the hazard unit holds issue of any instruction reading or writing a query_hit register. The arbiter itself does not reorder.
- No flush input: the long-latency unit only presents results for committed ops.

Decomposition:
- Add to def_common.vh:
  - struct lu2wb {rd[4:0], result[63:0]}
  - enum wb_arb_state {IDLE, WAIT, FORCE}
  - parameter for the RD index width
- Sub-module wb_arb_fifo: DEPTH-entry circular buffer of lu2wb. Outputs head, count and the per-entry rd vector used for query_hit.

Test Plan:
- Reset, pipe idle, lu push rd=5 data=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, fifo_count returns to 0.
- pipe busy rd=3 every cycle, lu push rd=7 -> rf writes rd=3 only. After 8 waiting cycles stall_req=1. First cycle with pipe_rd_en=0 writes rd=7, and stall_req=0 the following cycle.
- Push 4 results with pipe busy -> lu_ready=0 and fifo_count=4. Fifth lu_valid held until a pop. Drain order is FIFO.
- Pipe write with pipe_rd=0 and FIFO holding rd=9 -> rd=9 is written that cycle.
- FIFO holds rd=12: query_rd=12 gives query_hit=1, query_rd=0 gives 0. After drain, query_rd=12 gives 0.
- rst asserted mid-WAIT with 3 entries -> all outputs zero immediately, lu_ready=1, no subsequent rf_we.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds the FIFO entry layout (lu2wb_t), the arbiter state encoding and the
// register-index width shared by the arbiter and its FIFO.
package wb_port_arbiter_pkg;

  localparam int RD_W   = 5;
  localparam int DATA_W = 64;

  // One long-latency result waiting for a write-back slot.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] result;
  } lu2wb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Circular buffer of DEPTH long-latency results awaiting a write-back slot.
// Latency: a pushed entry is visible at head_o the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
// Ports: push_i/push_dat_i enqueue, pop_i dequeues head_o; count_o is the
// occupancy; ent_rd_o/ent_vld_o expose every slot's rd for pending lookups.
module wb_port_arbiter_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  lu2wb_t                      push_dat_i,
  input  logic                        pop_i,
  output lu2wb_t                      head_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [DEPTH*RD_W-1:0]       ent_rd_o,
  output logic [DEPTH-1:0]            ent_vld_o
);

  localparam int AW = $clog2(DEPTH);

  lu2wb_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;

  // Payload storage carries no reset; validity comes from count/pointers.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [AW-1:0] off;
    off       = '0;
    ent_vld_o = '0;
    ent_rd_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off                       = AW'(i) - rd_ptr_q;
      ent_vld_o[i]              = ({1'b0, off} < count_q);
      ent_rd_o[i*RD_W +: RD_W]  = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back and a
// long-latency result FIFO. Latency: pipe writes same cycle; FIFO head writes
// in the first free slot, at least 1 cycle after push. Backpressure: lu_ready
// drops when the FIFO is full; pipe is never stalled, stall_req asks for a
// bubble once the head has starved for STARVE_LIMIT cycles.
// Ports: pipe_* write-back request; lu_* result stream; rf_* write port;
// query_rd/query_hit pending-rd lookup; fifo_count occupancy.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_rd_en,
  input  logic [4:0]             pipe_rd,
  input  logic [63:0]            pipe_result,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [4:0]             lu_rd,
  input  logic [63:0]            lu_result,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [63:0]            rf_wdata,
  output logic                   stall_req,
  input  logic [4:0]             query_rd,
  output logic                   query_hit,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_e         state_q, state_d;
  logic [SW-1:0]         wait_q, wait_d;

  logic                  busy;
  logic                  push;
  logic                  pop;
  logic                  drain_wr;
  logic                  left_nonempty;
  lu2wb_t                push_dat;
  lu2wb_t                head;
  logic [AW:0]           count;
  logic [DEPTH*RD_W-1:0] ent_rd;
  logic [DEPTH-1:0]      ent_vld;

  // rd=0 is a no-op write; holding reset also blocks any write-back.
  assign busy     = rst && pipe_rd_en && (pipe_rd != '0);
  assign lu_ready = (count != (AW+1)'(DEPTH));
  assign push     = lu_valid && lu_ready;
  assign pop      = !busy && (count != '0);
  // Entries for rd=0 are popped silently.
  assign drain_wr = pop && (head.rd != '0);
  // Only meaningful when popping (count >= 1).
  assign left_nonempty = (count != (AW+1)'(1)) || push;

  assign push_dat.rd     = lu_rd;
  assign push_dat.result = lu_result;

  wb_port_arbiter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .ent_rd_o   (ent_rd),
    .ent_vld_o  (ent_vld)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (busy) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_result;
    end else if (drain_wr) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.result;
    end
  end

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i*RD_W +: RD_W] == query_rd) && (query_rd != '0)) begin
        query_hit = 1'b1;
      end
    end
  end

  // Starvation FSM: wait_q counts cycles the head has been passed over.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = WAIT;
          wait_d  = '0;
        end
      end
      WAIT: begin
        if (pop) begin
          wait_d  = '0;
          state_d = left_nonempty ? WAIT : IDLE;
        end else begin
          if (wait_q != SW'(STARVE_LIMIT)) wait_d = wait_q + SW'(1);
          if (wait_d == SW'(STARVE_LIMIT)) state_d = FORCE;
        end
      end
      FORCE: begin
        if (pop) begin
          wait_d  = '0;
          state_d = left_nonempty ? WAIT : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign stall_req  = (state_q == FORCE);
  assign fifo_count = count;

endmodule
